ball_motion: RTL

//  Parametrised ball position/velocity engine for the brick-breaker playfield.
//  - Serves the ball from a start point, waits for a launch, then moves it on each `tick`.
//  - Reflects off the side and top walls internally.
//  - Applies external brick/paddle collision flips and reports a lost ball at the floor.
//  - Sits between the game-state FSM and the renderer/collision logic.

---
 rtl/ball_motion.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ball_motion.sv
// Ball position/velocity engine: serve, launch, wall reflection, collision flips.
// Optional BALL_SPEEDUP_EN: each consumed Y collision flip speeds up both axes.
module ball_motion #(
  parameter int XW       = 8,
  parameter int YW       = 8,
  parameter int VW       = 3,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 159,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 119,
  parameter int START_X  = 20,
  parameter int START_Y  = 20,
  parameter int START_VX = 1,
  parameter int START_VY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick,
  input  logic [2:0]    state,
  input  logic          launch,
  input  logic          cX,
  input  logic          cY,
  output logic [XW-1:0] posX,
  output logic [YW-1:0] posY,
  output logic [VW-1:0] vX,
  output logic [VW-1:0] vY,
  output logic          dirX,
  output logic          dirY,
  output logic          moving,
  output logic          lost
);

`ifdef BALL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SERVE, MOVE, LOST} fsm_t;

  fsm_t          fsm, fsm_n;
  logic [XW-1:0] posX_n;
  logic [YW-1:0] posY_n;
  logic [VW-1:0] vX_n, vY_n;
  logic          dirX_n, dirY_n;
  logic          pendX, pendY;
  logic          pendX_n, pendY_n;
  logic          lost_n;
  logic          reload;
  logic          play;

  // One extra bit on every step calculation so nothing wraps.
  logic [XW:0] wx, wvx, sx, lx;
  logic [YW:0] wy, wvy, sy, ly;
  logic        fx, fy, ex, ey;

  assign play = (state == 3'b001);

  assign wx  = (XW+1)'(posX);
  assign wvx = (XW+1)'(vX);
  assign sx  = wx + wvx;
  assign lx  = (XW+1)'(X_MIN) + wvx;
  assign wy  = (YW+1)'(posY);
  assign wvy = (YW+1)'(vY);
  assign sy  = wy + wvy;
  assign ly  = (YW+1)'(Y_MIN) + wvy;

  assign fx = pendX | cX;
  assign fy = pendY | cY;
  assign ex = dirX ^ fx;
  assign ey = dirY ^ fy;

  assign moving = (fsm == MOVE);

  always_comb begin
    fsm_n   = fsm;
    posX_n  = posX;
    posY_n  = posY;
    vX_n    = vX;
    vY_n    = vY;
    dirX_n  = dirX;
    dirY_n  = dirY;
    pendX_n = pendX;
    pendY_n = pendY;
    lost_n  = 1'b0;
    reload  = 1'b0;
    if (!play) begin
      fsm_n  = IDLE;
      reload = 1'b1;
    end else begin
      unique case (fsm)
        IDLE: begin
          reload = 1'b1;
          fsm_n  = SERVE;
        end
        SERVE: begin
          reload = 1'b1;
          if (launch) fsm_n = MOVE;
        end
        MOVE: begin
          if (tick) begin
            pendX_n = 1'b0;
            pendY_n = 1'b0;
            // Walls override whatever direction the flips produced.
            if (!ex) begin
              if (sx >= (XW+1)'(X_MAX)) begin
                posX_n = XW'(X_MAX);
                dirX_n = 1'b1;
              end else begin
                posX_n = sx[XW-1:0];
                dirX_n = 1'b0;
              end
            end else begin
              if (wx < lx) begin
                posX_n = XW'(X_MIN);
                dirX_n = 1'b0;
              end else begin
                posX_n = posX - XW'(vX);
                dirX_n = 1'b1;
              end
            end
            if (!ey) begin
              dirY_n = 1'b0;
              if (sy > (YW+1)'(Y_MAX)) begin
                posY_n = YW'(Y_MAX);
                lost_n = 1'b1;
                fsm_n  = LOST;
              end else begin
                posY_n = sy[YW-1:0];
              end
            end else begin
              if (wy < ly) begin
                posY_n = YW'(Y_MIN);
                dirY_n = 1'b0;
              end else begin
                posY_n = posY - YW'(vY);
                dirY_n = 1'b1;
              end
            end
            if (SPEEDUP && fy) begin
              vX_n = (vX == '1) ? vX : vX + 1'b1;
              vY_n = (vY == '1) ? vY : vY + 1'b1;
            end
          end else begin
            pendX_n = fx;
            pendY_n = fy;
          end
        end
        LOST: begin
          reload = 1'b1;
          fsm_n  = SERVE;
        end
        default: begin
          reload = 1'b1;
          fsm_n  = IDLE;
        end
      endcase
    end
    if (reload) begin
      posX_n  = XW'(START_X);
      posY_n  = YW'(START_Y);
      vX_n    = VW'(START_VX);
      vY_n    = VW'(START_VY);
      dirX_n  = 1'b0;
      dirY_n  = 1'b0;
      pendX_n = 1'b0;
      pendY_n = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm   <= IDLE;
      posX  <= XW'(START_X);
      posY  <= YW'(START_Y);
      vX    <= VW'(START_VX);
      vY    <= VW'(START_VY);
      dirX  <= 1'b0;
      dirY  <= 1'b0;
      pendX <= 1'b0;
      pendY <= 1'b0;
      lost  <= 1'b0;
    end else begin
      fsm   <= fsm_n;
      posX  <= posX_n;
      posY  <= posY_n;
      vX    <= vX_n;
      vY    <= vY_n;
      dirX  <= dirX_n;
      dirY  <= dirY_n;
      pendX <= pendX_n;
      pendY <= pendY_n;
      lost  <= lost_n;
    end
  end

endmodule
